// File: rtl/halftone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : halftone_pkg
// Description : Shared widths, Floyd-Steinberg weights and clamp helper for
//               the halftone error-diffusion stage.
// Revision    : 1.0 - initial release
// ============================================================================
package halftone_pkg;

   localparam int GRAY_W = 8;
   localparam int ERR_W  = 10;
   localparam int CORR_W = 11;

   // Floyd-Steinberg weights (sixteenths): right, down-left, down, down-right
   localparam int FS_R     = 7;
   localparam int FS_DL    = 3;
   localparam int FS_D     = 5;
   localparam int FS_DR    = 1;
   localparam int FS_SHIFT = 4;

   localparam logic signed [CORR_W-1:0] CLAMP_MIN = '0;
   localparam logic signed [CORR_W-1:0] CLAMP_MAX = 11'sd255;

   typedef logic signed [ERR_W-1:0] err_t;

   // Saturate the error-corrected value back into the 8-bit gray range
   function automatic logic [GRAY_W-1:0] clamp_gray(input logic signed [CORR_W-1:0] corr);
      logic [GRAY_W-1:0] v;
      if (corr < CLAMP_MIN) begin
         v = '0;
      end else if (corr > CLAMP_MAX) begin
         v = '1;
      end else begin
         v = corr[GRAY_W-1:0];
      end
      return v;
   endfunction

endpackage : halftone_pkg
`default_nettype wire

// File: rtl/halftone_fs_diffuser_fs_quantize.sv
`default_nettype none
// ============================================================================
// Module      : fs_quantize
// Description : Combinational core of one diffusion step: adds the pending
//               error to the gray pixel, clamps, thresholds and produces the
//               four floor-shifted weighted errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_quantize
   import halftone_pkg::*;
#(
   parameter int THRESH = 128
) (
   input  logic [GRAY_W-1:0] gray,
   input  err_t              acc,
   output logic              q,
   output err_t              w7,
   output err_t              w3,
   output err_t              w5,
   output err_t              w1
);

   // Products of the 9-bit error with weights up to 7 fit comfortably in 13 bits
   localparam int PROD_W = 13;
   localparam logic [GRAY_W-1:0] TH = GRAY_W'(THRESH);
   localparam logic signed [PROD_W-1:0] K_R  = PROD_W'(FS_R);
   localparam logic signed [PROD_W-1:0] K_DL = PROD_W'(FS_DL);
   localparam logic signed [PROD_W-1:0] K_D  = PROD_W'(FS_D);
   localparam logic signed [PROD_W-1:0] K_DR = PROD_W'(FS_DR);

   logic signed [CORR_W-1:0] corr;
   logic [GRAY_W-1:0]        v;
   logic signed [8:0]        v_ext;
   logic signed [8:0]        e;
   logic signed [PROD_W-1:0] e_ext;
   logic signed [PROD_W-1:0] s7, s3, s5, s1;

   // Correct, clamp, quantize and split the residual error into four weights
   always_comb begin
      corr  = $signed({{(CORR_W-GRAY_W){1'b0}}, gray})
            + $signed({{(CORR_W-ERR_W){acc[ERR_W-1]}}, acc});
      v     = clamp_gray(corr);
      q     = (v >= TH);
      v_ext = $signed({1'b0, v});
      e     = q ? (v_ext - 9'sd255) : v_ext;
      e_ext = $signed({{(PROD_W-9){e[8]}}, e});
      // Arithmetic shift gives floor division, matching the reference rounding
      s7    = (e_ext * K_R)  >>> FS_SHIFT;
      s3    = (e_ext * K_DL) >>> FS_SHIFT;
      s5    = (e_ext * K_D)  >>> FS_SHIFT;
      s1    = (e_ext * K_DR) >>> FS_SHIFT;
      w7    = s7[ERR_W-1:0];
      w3    = s3[ERR_W-1:0];
      w5    = s5[ERR_W-1:0];
      w1    = s1[ERR_W-1:0];
   end

endmodule : fs_quantize
`default_nettype wire

// File: rtl/halftone_fs_diffuser.sv
`default_nettype none
// ============================================================================
// Module      : halftone_fs_diffuser
// Description : Streaming Floyd-Steinberg halftoner. Converts a raster stream
//               of 8-bit gray pixels into 1-bit pixels, carrying error to the
//               right neighbour and into a one-row error buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module halftone_fs_diffuser
   import halftone_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int THRESH = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gray_valid,
   output logic              gray_ready,
   input  logic [GRAY_W-1:0] gray_in,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_out,
   output logic              pix_last
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   err_t             right_err;
   err_t             cur_err [IMG_W];
   err_t             nxt_err [IMG_W];
   err_t             nxt_upd [IMG_W];
   err_t             acc;
   err_t             w7, w3, w5, w1;
   logic             q;
   logic             accept;
   logic             last_col;
   logic             last_row;

   assign gray_ready = !pix_valid || pix_ready;
   assign accept     = gray_valid && gray_ready;
   assign last_col   = (col == LAST_COL);
   assign last_row   = (row == LAST_ROW);
   assign acc        = right_err + cur_err[col];

   fs_quantize #(
      .THRESH (THRESH)
   ) u_quant (
      .gray (gray_in),
      .acc  (acc),
      .q    (q),
      .w7   (w7),
      .w3   (w3),
      .w5   (w5),
      .w1   (w1)
   );

   // Next-row buffer after this pixel's contributions; also feeds the row swap
   always_comb begin
      for (int i = 0; i < IMG_W; i++) begin
         nxt_upd[i] = nxt_err[i];
         if (col == COL_W'(i)) begin
            // Column 0 starts a fresh row, so its slot is overwritten
            nxt_upd[i] = (i == 0) ? w5 : (nxt_err[i] + w5);
         end else if ((i < IMG_W - 1) && (col == COL_W'(i + 1))) begin
            nxt_upd[i] = nxt_err[i] + w3;
         end else if ((i > 0) && (col == COL_W'(i - 1))) begin
            // First contribution to this slot in the row, so assign
            nxt_upd[i] = w1;
         end
      end
   end

   // Raster position and error storage, advanced on every accepted pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col       <= '0;
         row       <= '0;
         right_err <= '0;
         for (int i = 0; i < IMG_W; i++) begin
            cur_err[i] <= '0;
            nxt_err[i] <= '0;
         end
      end else if (accept) begin
         nxt_err <= nxt_upd;
         if (last_col) begin
            col       <= '0;
            right_err <= '0;
            if (last_row) begin
               // Frame end: bottom-row error is dropped, next frame starts clean
               row <= '0;
               for (int i = 0; i < IMG_W; i++) begin
                  cur_err[i] <= '0;
               end
            end else begin
               row     <= row + 1'b1;
               cur_err <= nxt_upd;
            end
         end else begin
            col       <= col + 1'b1;
            right_err <= w7;
         end
      end
   end

   // Output register: loads on accept, holds under backpressure
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_valid <= 1'b0;
         pix_out   <= 1'b0;
         pix_last  <= 1'b0;
      end else if (accept) begin
         pix_valid <= 1'b1;
         pix_out   <= q;
         pix_last  <= last_col && last_row;
      end else if (pix_ready) begin
         pix_valid <= 1'b0;
      end
   end

endmodule : halftone_fs_diffuser
`default_nettype wire

// File: doc/halftone_fs_diffuser.md
Name: halftone_fs_diffuser

Overview:
- Consumes the 8-bit gray pixel stream produced by the grayscale stage, in raster order over a fixed IMG_W x IMG_H frame.
- Emits a 1-bit halftone pixel per input using Floyd-Steinberg error diffusion.
- Sits directly downstream of the grayscale converter, with valid/ready on both sides.
- Holds one row of pending next-row error plus one pending right-neighbour error.

Parameters:
- IMG_W, 16, pixels per row (>=2).
- IMG_H, 16, rows per frame (>=1).
- THRESH, 128, quantize threshold; pixel is 1 when clamped corrected value >= THRESH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- gray_valid  in  1  gray_in is valid.
- gray_ready  out  1  block can accept gray_in this cycle.
- gray_in  in  8  gray pixel, unsigned.
- pix_valid  out  1  pix_out is valid.
- pix_ready  in  1  downstream accepts pix_out.
- pix_out  out  1  halftone pixel (1 = white/255, 0 = black/0).
- pix_last  out  1  qualifies pix_out as last pixel of frame.

Behaviour:
- Reset (async, active-high):
  - pix_valid=0, pix_out=0, pix_last=0.
  - col=0, row=0, right_err=0.
  - Both error row buffers cleared to 0.
- Handshake:
  - gray_ready = !pix_valid || pix_ready.
  - Input accepted on gray_valid && gray_ready.
  - Result is registered: pix_valid rises the cycle after accept, so latency is 1 and throughput is 1 pixel/clk.
  - While pix_valid && !pix_ready: pix_out and pix_last hold stable, and no input is accepted.
- Per accepted pixel (row r, col c):
  - acc = right_err + cur_err[c], 10-bit signed.
  - corr = gray_in + acc, 11-bit signed; clamp to 0..255 giving v.
  - q = (v >= THRESH); e = v - (q ? 255 : 0), range -127..127, 9-bit signed.
- Weighted errors, arithmetic shift right 4 (floor):
  - w7 = (7*e)>>>4, w3 = (3*e)>>>4, w5 = (5*e)>>>4, w1 = e>>>4.
- Distribution of weighted errors:
  - right_err <= (c == IMG_W-1) ? 0 : w7.
  - nxt_err[c] <= (c == 0) ? w5 : nxt_err[c] + w5.
  - If c > 0: nxt_err[c-1] <= nxt_err[c-1] + w3.
  - If c < IMG_W-1: nxt_err[c+1] <= w1 (assignment, not accumulate; this is its first contribution in the row).
  - Errors falling off the left or right edge are discarded.
  - Errors from row IMG_H-1 into the next row are discarded at frame end.
- End of row (c == IMG_W-1):
  - col <= 0, row <= row+1.
  - cur_err <= nxt_err; the swap includes that cycle's final nxt updates.
- End of frame (c == IMG_W-1 && row == IMG_H-1):
  - pix_last=1 with that pixel.
  - row <= 0, right_err <= 0, cur_err <= 0 for all columns.
  - Next accepted pixel is (0,0) of a fresh frame with zero error.
- Reset asserted mid-frame: all state is cleared and any pending output is dropped. The first pixel after reset is (0,0).
- No other frame-boundary input exists; framing comes purely from counting.

Decomposition:
- Package halftone_pkg:
  - GRAY_W=8, ERR_W=10, CORR_W=11.
  - Weights FS_R=7, FS_DL=3, FS_D=5, FS_DR=1, FS_SHIFT=4.
  - Clamp limits 0/255.
- One combinational sub-module, fs_quantize:
  - Inputs: gray, acc. Outputs: q, w7, w3, w5, w1.
  - Keeps the arithmetic unit-testable.
- Top module holds the counters, right_err, the two IMG_W-entry error arrays (register arrays; combinational read) and the output register.

Test Plan:
- IMG_W=4, IMG_H=2, all gray_in=0, pix_ready=1 -> 8 outputs all 0; pix_last only on 8th; latency 1 cycle.
- All gray_in=255 -> all pix_out=1, e=0 throughout.
- First two pixels 128, 128 -> pixel0 = 1 with e=-127, w7=-56. Pixel1: corr=72 so pix_out=0, e=72, w7=31.
- Error carry across rows:
  - Row0 = {200, 0, 0, 0}: pixel0 gives e=-55, w5=-18, w1=-4.
  - Row1 col0 = 100 -> corr=82, output 0.
  - Row1 col1 accumulates cur_err=-4 plus the row-1 right error.
  - Compare against a bit-exact C model.
- Backpressure: pix_ready=0 for 3 cycles mid-row -> gray_ready=0, pix_out/pix_last stable. Releasing it resumes with no pixel lost or duplicated, matching the C model.
- Reset mid-frame (after 5 of 8 pixels) -> pix_valid=0 immediately. Next 8 pixels of 128 reproduce scenario-3 results from pixel (0,0), with pix_last on the 8th.
